// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg -- shared definitions for the 4x4 keypad scanner and the
// consumers of its key codes (FSM state encoding, column drive patterns,
// key_code field layout, row priority helper).
package keypad_scan_pkg;

   typedef enum logic [1:0] {
      ST_SCAN    = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_HELD    = 2'd2,
      ST_RELEASE = 2'd3
   } scan_state_t;

   // Result of looking for the lowest-index low row.
   typedef struct packed {
      logic       hit;
      logic [1:0] idx;
   } row_hit_t;

   // Column drive after reset (column 0 driven low).
   localparam logic [3:0] COL_RESET = 4'b1110;

   // key_code = {column index, row index}
   localparam int CODE_COL_MSB = 3;
   localparam int CODE_COL_LSB = 2;
   localparam int CODE_ROW_MSB = 1;
   localparam int CODE_ROW_LSB = 0;

   // Active-low column drive pattern for a column index.
   function automatic logic [3:0] col_drive(input logic [1:0] col);
      logic [3:0] drv;
      case (col)
         2'd0:    drv = 4'b1110;
         2'd1:    drv = 4'b1101;
         2'd2:    drv = 4'b1011;
         2'd3:    drv = 4'b0111;
         default: drv = COL_RESET;
      endcase
      return drv;
   endfunction

   // Pack column and row indices into a key code.
   function automatic logic [3:0] make_code(input logic [1:0] col, input logic [1:0] row);
      logic [3:0] code;
      code = 4'b0000;
      code[CODE_COL_MSB:CODE_COL_LSB] = col;
      code[CODE_ROW_MSB:CODE_ROW_LSB] = row;
      return code;
   endfunction

   // Lowest-index row that is pulled low; row 0 has priority.
   function automatic row_hit_t lowest_low(input logic [3:0] row_n);
      row_hit_t res;
      if (!row_n[0]) begin
         res = '{hit: 1'b1, idx: 2'd0};
      end else if (!row_n[1]) begin
         res = '{hit: 1'b1, idx: 2'd1};
      end else if (!row_n[2]) begin
         res = '{hit: 1'b1, idx: 2'd2};
      end else if (!row_n[3]) begin
         res = '{hit: 1'b1, idx: 2'd3};
      end else begin
         res = '{hit: 1'b0, idx: 2'd0};
      end
      return res;
   endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// keypad_scan_if -- keypad matrix lines plus key event outputs.
//   row_n     : keypad rows, active-low (keypad -> scanner)
//   col_n     : column drive, active-low one-cold (scanner -> keypad)
//   key_code  : {col[1:0], row[1:0]} of the last accepted key
//   key_valid : one-cycle pulse on an accepted press
//   key_long  : one-cycle pulse when a press reaches the long-press time
//   key_held  : level, key currently accepted as down
// master = scanner side, slave = keypad / consumer side.
interface keypad_scan_if;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_long;
   logic       key_held;

   modport master (input  row_n,
                   output col_n, key_code, key_valid, key_long, key_held);
   modport slave  (output row_n,
                   input  col_n, key_code, key_valid, key_long, key_held);
endinterface

// File: rtl/keypad_scan_tick_gen.sv
// keypad_tick_gen -- row synchroniser and scan-slot prescaler.
//   clk, rst_n : clock, async active-low reset
//   row_n      : raw keypad rows (asynchronous)
//   row_sync   : rows after a two-flop synchroniser (idle = 1111)
//   slot_tick  : high for one clk every SCAN_DIV clocks (free running)
module keypad_tick_gen #(
   parameter int SCAN_DIV = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_n,
   output logic [3:0] row_sync,
   output logic       slot_tick
);

   localparam int              DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [3:0]       sync_meta_r;
   logic [3:0]       sync_r;
   logic [DIV_W-1:0] div_cnt_r;

   // Two-flop synchroniser for the asynchronous row inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta_r <= 4'b1111;
         sync_r      <= 4'b1111;
      end else begin
         sync_meta_r <= row_n;
         sync_r      <= sync_meta_r;
      end
   end

   // Free-running prescaler 0..SCAN_DIV-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else if (div_cnt_r == DIV_LAST) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else begin
         div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
   end

   assign row_sync  = sync_r;
   assign slot_tick = (div_cnt_r == DIV_LAST);

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan -- 4x4 matrix keypad scanner with press/release debounce and
// long-press detection.
//   clk, rst_n : clock, async active-low reset
//   bus        : keypad_scan_if master (row_n in; col_n, key_code,
//                key_valid, key_long, key_held out)
// The column rotates once per scan slot until a row goes low; it then stays
// parked on that column until the release has been debounced.
module keypad_scan
   import keypad_scan_pkg::*;
#(
   parameter int SCAN_DIV   = 20,
   parameter int DEBOUNCE   = 4,
   parameter int LONG_TICKS = 500
) (
   input  logic          clk,
   input  logic          rst_n,
   keypad_scan_if.master bus
);

   localparam int               DB_W     = $clog2(DEBOUNCE + 1);
   localparam int               HOLD_W   = $clog2(LONG_TICKS + 1);
   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_TICKS - 1);

   logic [3:0] row_sync_s;
   logic       slot_tick_s;

   keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_n     (bus.row_n),
      .row_sync  (row_sync_s),
      .slot_tick (slot_tick_s)
   );

   scan_state_t       state_r,     state_s;
   logic [1:0]        col_r,       col_s;
   logic [1:0]        cand_r,      cand_s;
   logic [DB_W-1:0]   match_cnt_r, match_cnt_s;
   logic [DB_W-1:0]   rel_cnt_r,   rel_cnt_s;
   logic [HOLD_W-1:0] hold_cnt_r,  hold_cnt_s;
   logic [3:0]        key_code_r,  key_code_s;
   logic              key_valid_r, key_valid_s;
   logic              key_long_r,  key_long_s;
   logic              key_held_r,  key_held_s;
   logic [3:0]        col_n_r;
   row_hit_t          hit_s;
   logic              cand_low_s;

   // Next-state, counters and output events; all decisions happen on slot_tick.
   always_comb begin
      state_s     = state_r;
      col_s       = col_r;
      cand_s      = cand_r;
      match_cnt_s = match_cnt_r;
      rel_cnt_s   = rel_cnt_r;
      hold_cnt_s  = hold_cnt_r;
      key_code_s  = key_code_r;
      key_valid_s = 1'b0;
      key_long_s  = 1'b0;
      key_held_s  = key_held_r;
      hit_s       = lowest_low(row_sync_s);
      cand_low_s  = ~row_sync_s[cand_r];

      if (slot_tick_s) begin
         case (state_r)
            ST_SCAN: begin
               if (hit_s.hit) begin
                  cand_s      = hit_s.idx;
                  match_cnt_s = DB_W'(1);
                  state_s     = ST_CONFIRM;
               end else begin
                  col_s = col_r + 2'd1;
               end
            end
            ST_CONFIRM: begin
               // A different lowest row counts as a bounce, not a new candidate.
               if (hit_s.hit && (hit_s.idx == cand_r)) begin
                  if (match_cnt_r == DB_LAST) begin
                     key_code_s  = make_code(col_r, cand_r);
                     key_valid_s = 1'b1;
                     key_held_s  = 1'b1;
                     hold_cnt_s  = {HOLD_W{1'b0}};
                     state_s     = ST_HELD;
                  end else begin
                     match_cnt_s = match_cnt_r + DB_W'(1);
                  end
               end else begin
                  col_s   = col_r + 2'd1;
                  state_s = ST_SCAN;
               end
            end
            ST_HELD: begin
               if (cand_low_s) begin
                  // Saturating count; the pulse fires only on reaching the limit.
                  if (hold_cnt_r != HOLD_MAX) begin
                     hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                     key_long_s = (hold_cnt_r == HOLD_PRE);
                  end else begin
                     hold_cnt_s = hold_cnt_r;
                  end
               end else begin
                  rel_cnt_s = DB_W'(1);
                  state_s   = ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (cand_low_s) begin
                  state_s = ST_HELD;
               end else if (rel_cnt_r == DB_LAST) begin
                  key_held_s = 1'b0;
                  col_s      = col_r + 2'd1;
                  state_s    = ST_SCAN;
               end else begin
                  rel_cnt_s = rel_cnt_r + DB_W'(1);
               end
            end
            default: begin
               state_s = ST_SCAN;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_SCAN;
         col_r       <= 2'd0;
         cand_r      <= 2'd0;
         match_cnt_r <= {DB_W{1'b0}};
         rel_cnt_r   <= {DB_W{1'b0}};
         hold_cnt_r  <= {HOLD_W{1'b0}};
         key_code_r  <= 4'b0000;
         key_valid_r <= 1'b0;
         key_long_r  <= 1'b0;
         key_held_r  <= 1'b0;
         col_n_r     <= COL_RESET;
      end else begin
         state_r     <= state_s;
         col_r       <= col_s;
         cand_r      <= cand_s;
         match_cnt_r <= match_cnt_s;
         rel_cnt_r   <= rel_cnt_s;
         hold_cnt_r  <= hold_cnt_s;
         key_code_r  <= key_code_s;
         key_valid_r <= key_valid_s;
         key_long_r  <= key_long_s;
         key_held_r  <= key_held_s;
         col_n_r     <= col_drive(col_s);
      end
   end

   assign bus.col_n     = col_n_r;
   assign bus.key_code  = key_code_r;
   assign bus.key_valid = key_valid_r;
   assign bus.key_long  = key_long_r;
   assign bus.key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan -- self-checking bench for keypad_scan with a keypad matrix
// model and an expected-key-code scoreboard.
module tb_keypad_scan;

   localparam int SCAN_DIV   = 4;
   localparam int DEBOUNCE   = 4;
   localparam int LONG_TICKS = 20;
   localparam int BUDGET     = 60 * SCAN_DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   keypad_scan_if bus();

   keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .LONG_TICKS(LONG_TICKS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   // Keypad matrix: pressed[col*4+row] pulls that row low while its column is driven.
   logic [15:0] pressed = 16'h0000;
   logic [3:0]  row_model;
   always_comb begin
      row_model = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (pressed[c*4+r] && !bus.col_n[c]) row_model[r] = 1'b0;
         end
      end
   end
   assign bus.row_n = row_model;

   int errors = 0;
   int checks = 0;
   logic [3:0] exp_q[$];
   int rd_idx = 0;

   // Monitor-owned observations.
   int         cyc = 0;
   int         valid_cnt = 0;
   int         long_cnt = 0;
   int         valid_cyc = 0;
   int         long_cyc = 0;
   int         excl_bad = 0;
   int         onehot_bad = 0;
   int         col_changes = 0;
   logic [3:0] prev_col = 4'b1110;
   logic [3:0] obs_codes [64];

   // Output monitor, sampled away from the active edge.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rst_n) begin
         if (bus.key_valid) begin
            if (valid_cnt < 64) obs_codes[valid_cnt] <= bus.key_code;
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
         end
         if (bus.key_long) begin
            long_cnt <= long_cnt + 1;
            long_cyc <= cyc;
         end
         if (bus.key_valid && bus.key_long) excl_bad <= excl_bad + 1;
         if ($countones(~bus.col_n) != 1) onehot_bad <= onehot_bad + 1;
         if (bus.col_n != prev_col) col_changes <= col_changes + 1;
         prev_col <= bus.col_n;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic slots(input int n);
      repeat (n * SCAN_DIV) @(negedge clk);
   endtask

   task automatic wait_valid(input int target, input string tag);
      int n = 0;
      while (valid_cnt < target && n < BUDGET) begin
         tick();
         n++;
      end
      tick();
      check_eq(tag, valid_cnt, target);
   endtask

   task automatic wait_held(input logic level, input string tag);
      int n = 0;
      while (bus.key_held !== level && n < BUDGET) begin
         tick();
         n++;
      end
      check_eq(tag, bus.key_held, level);
   endtask

   // Compare observed key codes against the scoreboard in order.
   task automatic drain_sb(input string tag);
      while (exp_q.size() > 0 && rd_idx < valid_cnt) begin
         check_eq(tag, obs_codes[rd_idx], exp_q.pop_front());
         rd_idx++;
      end
      check_eq({tag, "_pending"}, exp_q.size() + (valid_cnt - rd_idx), 0);
   endtask

   task automatic check_rotation(input string tag);
      int c0;
      c0 = col_changes;
      slots(6);
      tick();
      check_eq(tag, (col_changes - c0) >= 3, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_col_n"},     bus.col_n,     4'b1110);
      check_eq({tag, "_key_code"},  bus.key_code,  4'b0000);
      check_eq({tag, "_key_valid"}, bus.key_valid, 1'b0);
      check_eq({tag, "_key_long"},  bus.key_long,  1'b0);
      check_eq({tag, "_key_held"},  bus.key_held,  1'b0);
   endtask

   initial begin
      int v0, l0, c0, rel_cyc;

      #1 rst_n = 1'b0;
      #20;
      @(negedge clk);
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Row 2 on column 1.
      pressed[1*4+2] = 1'b1;
      exp_q.push_back(4'b0110);
      wait_valid(1, "c1r2_valid");
      drain_sb("c1r2_code");
      check_eq("c1r2_held", bus.key_held, 1'b1);
      check_eq("c1r2_parked", bus.col_n, 4'b1101);
      @(negedge clk);
      pressed = 16'h0000;
      wait_held(1'b0, "c1r2_release");
      check_rotation("c1r2_rotation");

      // Bounce on row 0 / column 0: alternate every slot.
      v0 = valid_cnt;
      c0 = col_changes;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         pressed[0] = ~pressed[0];
         repeat (SCAN_DIV - 1) @(negedge clk);
      end
      @(negedge clk);
      pressed = 16'h0000;
      slots(6);
      tick();
      check_eq("bounce_no_valid", valid_cnt, v0);
      check_eq("bounce_rotation", (col_changes - c0) >= 8, 1);
      check_eq("bounce_held", bus.key_held, 1'b0);

      // Long press on row 1 / column 3.
      l0 = long_cnt;
      @(negedge clk);
      pressed[3*4+1] = 1'b1;
      exp_q.push_back(4'b1101);
      wait_valid(2, "long_valid");
      drain_sb("long_code");
      begin
         int n = 0;
         while (long_cnt == l0 && n < (LONG_TICKS + 10) * SCAN_DIV) begin
            tick();
            n++;
         end
      end
      check_eq("long_seen", long_cnt - l0, 1);
      check_eq("long_delay", long_cyc - valid_cyc, LONG_TICKS * SCAN_DIV);
      slots(10);
      tick();
      check_eq("long_once", long_cnt - l0, 1);
      check_eq("long_held", bus.key_held, 1'b1);

      // One-slot release glitch, then re-press: stays held, no new events.
      @(negedge clk);
      pressed[3*4+1] = 1'b0;
      repeat (SCAN_DIV) @(negedge clk);
      pressed[3*4+1] = 1'b1;
      slots(DEBOUNCE + 2);
      tick();
      check_eq("glitch_held", bus.key_held, 1'b1);
      check_eq("glitch_no_valid", valid_cnt, 2);
      check_eq("glitch_no_long", long_cnt - l0, 1);
      @(negedge clk);
      pressed = 16'h0000;
      wait_held(1'b0, "glitch_release");
      check_rotation("glitch_rotation");

      // Rows 1 and 3 on column 2: lowest row wins.
      @(negedge clk);
      pressed[2*4+1] = 1'b1;
      pressed[2*4+3] = 1'b1;
      exp_q.push_back(4'b1001);
      wait_valid(3, "dual_valid");
      drain_sb("dual_code");
      @(negedge clk);
      pressed = 16'h0000;
      wait_held(1'b0, "dual_release");

      // Reset while held, key stays down and is re-debounced.
      @(negedge clk);
      pressed[1*4+0] = 1'b1;
      exp_q.push_back(4'b0100);
      wait_valid(4, "rst_first_valid");
      drain_sb("rst_first_code");
      slots(3);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 rel_cyc = cyc;
      exp_q.push_back(4'b0100);
      wait_valid(5, "rst_again_valid");
      drain_sb("rst_again_code");
      check_eq("rst_redebounce", (valid_cyc - rel_cyc) >= DEBOUNCE * SCAN_DIV, 1);
      check_eq("rst_again_held", bus.key_held, 1'b1);
      @(negedge clk);
      pressed = 16'h0000;
      wait_held(1'b0, "rst_release");

      check_eq("valid_long_exclusive", excl_bad, 0);
      check_eq("col_one_cold", onehot_bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 20: clk cycles per scan slot (min 4).
REQ-002 Parameter DEBOUNCE, default 4: consecutive matching slot samples needed to accept a press or a release (min 2).
REQ-003 Parameter LONG_TICKS, default 500: held-slot samples before the long-press event.
REQ-004 clk  in  1  system clock (the divided 10 kHz counter clock in the top level).
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 row_n  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-007 col_n  out  4  keypad column drive, active-low, exactly one bit low at all times after reset.
REQ-008 key_code  out  4  accepted key, {column index[1:0], row index[1:0]}.
REQ-009 key_valid  out  1  one-cycle pulse when a press is accepted.
REQ-010 key_long  out  1  one-cycle pulse when an accepted press reaches LONG_TICKS.
REQ-011 key_held  out  1  level, high from key_valid until the release is accepted.

Function
REQ-012 row_n SHALL pass through a two-flop synchroniser; all decisions use the synchronised value.
REQ-013 A prescaler SHALL count 0..SCAN_DIV-1; slot_tick is asserted on the count SCAN_DIV-1, and rows are sampled only on slot_tick.
REQ-014 The FSM SHALL have states SCAN, CONFIRM, HELD and RELEASE.
REQ-015 SCAN: on each slot_tick with no row low, the column SHALL advance 0->1->2->3->0 (col_n 1110->1101->1011->0111->1110).
REQ-016 SCAN: on a slot_tick with any row low, the block SHALL capture the lowest-index low row as the candidate, set the match count to 1, park the column and enter CONFIRM.
REQ-017 CONFIRM: on each slot_tick, if the candidate row alone is the lowest low row, increment the count; otherwise return to SCAN and advance the column.
REQ-018 CONFIRM: when the count reaches DEBOUNCE, the block SHALL update key_code, pulse key_valid in the cycle after that slot_tick, set key_held, clear the hold count and enter HELD.
REQ-019 HELD: each slot_tick with the candidate row low SHALL increment the hold count, saturating; when it equals LONG_TICKS, key_long SHALL pulse once per press.
REQ-020 HELD: a slot_tick with the candidate row high SHALL set the release count to 1 and enter RELEASE.
REQ-021 RELEASE: a slot_tick with the row high SHALL increment the release count.
REQ-022 RELEASE: a slot_tick with the row low SHALL return to HELD; the hold count is preserved.
REQ-023 RELEASE: when the release count reaches DEBOUNCE, key_held SHALL clear in the next cycle, the column SHALL advance and the FSM SHALL enter SCAN.
REQ-024 The column SHALL stay parked throughout CONFIRM, HELD and RELEASE; presses on other columns are ignored until return to SCAN.
REQ-025 key_code SHALL hold its last accepted value until the next key_valid.
REQ-026 key_valid and key_long SHALL never assert in the same cycle.
REQ-027 The prescaler SHALL run freely in all states.

Reset
REQ-028 On rst_n low, asynchronously: state=SCAN, column 0 (col_n=1110), prescaler, all counts and synchronisers cleared (synchroniser to 1111), key_code=0, key_valid=0, key_long=0, key_held=0.
REQ-029 A reset mid-press SHALL discard the press with no pulse; a key still down after reset SHALL be re-debounced from SCAN.

Structure
REQ-030 The state encoding, the column-rotation constants and the key_code field positions SHALL live in the shared package, for the FSM and display consumers.
REQ-031 The synchroniser plus prescaler SHALL be one sub-module, keypad_tick_gen; the FSM and counters stay in keypad_scan.

Verification
REQ-032 SCAN_DIV=4, DEBOUNCE=4: hold row 2 low only while column 1 is driven, over 4 slots -> key_valid pulses once, key_code=0110, key_held=1.
REQ-033 Bounce: toggle row 0 low/high on alternate slots during CONFIRM -> no key_valid; the column resumes rotation.
REQ-034 Hold a key for LONG_TICKS+10 slots -> exactly one key_long, LONG_TICKS slots after key_valid; key_held stays 1.
REQ-035 Release glitch in RELEASE (1 slot high, then low) -> back to HELD, no second key_valid; after a clean 4-slot release, key_held=0 and rotation resumes.
REQ-036 Rows 1 and 3 low together on column 2 -> key_code=1001.
REQ-037 Assert rst_n low during HELD -> all outputs at reset values immediately; with the key still down, a new key_valid follows after DEBOUNCE slots.
